// File: rtl/led_pkg.sv
// Shared definitions for the LED driver: channel mode encodings and an index-width helper.
package led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Channel configuration write port shared by the register source and the LED driver.
interface led_pwm_ctrl_if
    import led_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int PWM_W  = 8
) ();

    localparam int CH_W = idx_w(CH_NUM);

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [MODE_W-1:0] cfg_mode;
    logic [PWM_W-1:0]  cfg_duty;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_duty
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_duty
    );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESC clocks; PRESC=1 ticks every cycle.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int PRESC = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = idx_w(PRESC);
    localparam logic [CW-1:0] PRE_LAST = CW'(PRESC - 1);

    logic [CW-1:0] r_pre_cnt;
    logic          w_last;

    assign w_last = (r_pre_cnt == PRE_LAST);
    assign tick   = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_last) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM on a shared time base,
// with duty shadowed and applied only at PWM period boundaries.
module led_pwm_ctrl
    import led_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int PRESC       = 50,
    parameter int PWM_W       = 8,
    parameter int BLINK_TICKS = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pwm_ctrl_if.slave     cfg,
    output logic [CH_NUM-1:0] led,
    output logic              period_start
);

    localparam int CH_W  = idx_w(CH_NUM);
    localparam int BLK_W = idx_w(BLINK_TICKS);
    localparam logic [PWM_W-1:0] PWM_MAX  = '1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic              w_tick;
    logic              w_wrap;
    logic              w_blink_last;
    logic              w_cfg_hit;
    logic [CH_NUM-1:0] w_led_nxt;

    logic [PWM_W-1:0]  r_pwm_cnt;
    logic              r_period_start;
    logic [BLK_W-1:0]  r_blink_cnt;
    logic              r_blink_ph;
    logic [CH_NUM-1:0] r_led;

    led_tick_gen #(
        .PRESC (PRESC)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_wrap       = w_tick && (r_pwm_cnt == PWM_MAX);
    assign w_blink_last = w_tick && (r_blink_cnt == BLK_LAST);
    // Out-of-range channel indices never reach any channel's select.
    assign w_cfg_hit    = cfg.cfg_we && (int'(cfg.cfg_ch) < CH_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
            r_blink_cnt    <= '0;
            r_blink_ph     <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            if (w_blink_last) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else if (w_tick) begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [MODE_W-1:0] r_mode;
        logic [PWM_W-1:0]  r_duty_sh;
        logic [PWM_W-1:0]  r_duty_act;
        logic              w_sel;

        assign w_sel = w_cfg_hit && (cfg.cfg_ch == CH_W'(i));

        // A write landing on the wrap edge loads the shadow after the old value was transferred.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode     <= MODE_OFF;
                r_duty_sh  <= '0;
                r_duty_act <= '0;
            end else begin
                if (w_sel) begin
                    r_mode    <= cfg.cfg_mode;
                    r_duty_sh <= cfg.cfg_duty;
                end
                if (w_wrap) begin
                    r_duty_act <= r_duty_sh;
                end
            end
        end

        assign w_led_nxt[i] = (r_mode == MODE_ON)
                            | ((r_mode == MODE_BLINK) & r_blink_ph)
                            | ((r_mode == MODE_PWM) & (r_pwm_cnt < r_duty_act));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign led          = r_led;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: table of mode writes plus hand-built PWM, blink and reset sequences.
module tb_led_pwm_ctrl;
    import led_pkg::*;

    localparam int CH_NUM      = 3;
    localparam int PRESC       = 2;
    localparam int PWM_W       = 4;
    localparam int BLINK_TICKS = 3;
    localparam int PERIOD_CLK  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH_NUM-1:0] led;
    logic              period_start;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    led_pwm_ctrl_if #(.CH_NUM(CH_NUM), .PWM_W(PWM_W)) u_if ();

    led_pwm_ctrl #(
        .CH_NUM      (CH_NUM),
        .PRESC       (PRESC),
        .PWM_W       (PWM_W),
        .BLINK_TICKS (BLINK_TICKS)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (u_if),
        .led          (led),
        .period_start (period_start)
    );

    typedef struct {
        logic              we;
        logic [1:0]        ch;
        logic [1:0]        mode;
        logic [PWM_W-1:0]  duty;
        logic [CH_NUM-1:0] exp_led;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                         input logic [PWM_W-1:0] duty);
        u_if.cfg_we   = we;
        u_if.cfg_ch   = ch;
        u_if.cfg_mode = mode;
        u_if.cfg_duty = duty;
    endtask

    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Call at the negedge of a period_start cycle; ends at the next period's start cycle.
    task automatic measure(input int ch, input int wr_at, input logic [PWM_W-1:0] wr_duty,
                           output int hi, output int first, output bit ps_next);
        hi    = 0;
        first = -1;
        for (int c = 0; c < PERIOD_CLK; c++) begin
            if (led[ch]) begin
                hi++;
                if (first < 0) first = c;
            end
            drive(c == wr_at, 2'd0, MODE_PWM, wr_duty);
            @(negedge clk);
        end
        u_if.cfg_we = 1'b0;
        ps_next = period_start;
    endtask

    task automatic run_period(input string name, input int wr_at, input logic [PWM_W-1:0] wr_duty,
                              input int exp_hi, input int exp_first);
        int hi, first;
        bit ps;
        measure(0, wr_at, wr_duty, hi, first, ps);
        chk({name, "_high"}, hi, exp_hi);
        chk({name, "_rise"}, first, exp_first);
        chk({name, "_period"}, int'(ps), 1);
    endtask

    initial begin
        logic [CH_NUM-1:0] prev_exp;
        int bad, cnt, gap_bad, last;
        bit ok;
        logic smp[60];
        int toggles, phase_bad, first_t, hi_win;

        vecs[0]  = '{1'b1, 2'd1, MODE_ON,  4'd0, 3'b010};
        vecs[1]  = '{1'b1, 2'd1, MODE_OFF, 4'd0, 3'b000};
        vecs[2]  = '{1'b1, 2'd3, MODE_ON,  4'd9, 3'b000};
        vecs[3]  = '{1'b1, 2'd0, MODE_ON,  4'd0, 3'b001};
        vecs[4]  = '{1'b1, 2'd2, MODE_ON,  4'd0, 3'b101};
        vecs[5]  = '{1'b1, 2'd3, MODE_OFF, 4'd0, 3'b101};
        vecs[6]  = '{1'b1, 2'd1, MODE_ON,  4'd0, 3'b111};
        vecs[7]  = '{1'b1, 2'd0, MODE_OFF, 4'd0, 3'b110};
        vecs[8]  = '{1'b1, 2'd2, MODE_OFF, 4'd0, 3'b010};
        vecs[9]  = '{1'b1, 2'd1, MODE_OFF, 4'd0, 3'b000};
        vecs[10] = '{1'b0, 2'd1, MODE_ON,  4'd0, 3'b000};

        drive(1'b0, 2'd0, MODE_OFF, 4'd0);
        rst_n = 1'b1;
        #4 rst_n = 1'b0;
        #8 rst_n = 1'b1;
        #1;
        chk("reset_led", int'(led), 0);
        chk("reset_period_start", int'(period_start), 0);

        bad = 0; cnt = 0; gap_bad = 0; last = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (led !== 3'b000) bad++;
            if (period_start) begin
                if (last >= 0 && (c - last) != PERIOD_CLK) gap_bad++;
                last = c;
                cnt++;
            end
        end
        chk("idle_led", bad, 0);
        chk("idle_ps_count", cnt, 6);
        chk("idle_ps_gap", gap_bad, 0);

        prev_exp = 3'b000;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].ch, vecs[i].mode, vecs[i].duty);
            @(negedge clk);
            chk($sformatf("vec%0d_edge_k", i), int'(led), int'(prev_exp));
            u_if.cfg_we = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_edge_k1", i), int'(led), int'(vecs[i].exp_led));
            prev_exp = vecs[i].exp_led;
        end

        wait_ps(ok);
        chk("pwm_sync0", int'(ok), 1);
        @(negedge clk);
        drive(1'b1, 2'd0, MODE_PWM, 4'd4);
        @(negedge clk);
        u_if.cfg_we = 1'b0;
        wait_ps(ok);
        chk("pwm_sync1", int'(ok), 1);
        run_period("duty4_a",        -1, 4'd0,  8,  1);
        run_period("duty4_b",        -1, 4'd0,  8,  1);
        run_period("mid_write_cur",  10, 4'd12, 8,  1);
        run_period("mid_write_next", -1, 4'd0,  24, 1);
        run_period("wrap_write_cur", 31, 4'd4,  24, 1);
        run_period("wrap_write_old", -1, 4'd0,  24, 1);
        run_period("wrap_write_new", -1, 4'd0,  8,  1);
        run_period("to_max_cur",     10, 4'd15, 8,  1);
        run_period("duty_max",       -1, 4'd0,  30, 1);
        run_period("to_zero_cur",    10, 4'd0,  30, 1);
        run_period("duty_zero",      -1, 4'd0,  0,  -1);

        @(negedge clk);
        drive(1'b1, 2'd2, MODE_BLINK, 4'd0);
        @(negedge clk);
        drive(1'b1, 2'd1, MODE_BLINK, 4'd0);
        @(negedge clk);
        u_if.cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        toggles = 0; gap_bad = 0; phase_bad = 0; last = -1; first_t = -1;
        for (int c = 0; c < 60; c++) begin
            smp[c] = led[2];
            if (led[1] !== led[2]) phase_bad++;
            if (c > 0 && smp[c] !== smp[c-1]) begin
                if (last >= 0 && (c - last) != PRESC * BLINK_TICKS) gap_bad++;
                if (first_t < 0) first_t = c;
                last = c;
                toggles++;
            end
            @(negedge clk);
        end
        hi_win = 0;
        if (first_t >= 0 && first_t <= 24) begin
            for (int c = first_t; c < first_t + 36; c++) hi_win += int'(smp[c]);
        end
        chk("blink_toggles", int'(toggles >= 9), 1);
        chk("blink_gap", gap_bad, 0);
        chk("blink_in_phase", phase_bad, 0);
        chk("blink_duty", hi_win, 18);
        chk("blink_pwm_zero", int'(led[0]), 0);

        drive(1'b1, 2'd1, MODE_ON, 4'd0);
        @(negedge clk);
        u_if.cfg_we = 1'b0;
        @(negedge clk);
        chk("pre_reset_on", int'(led[1]), 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #2 chk("async_reset_led", int'(led), 0);
        chk("async_reset_ps", int'(period_start), 0);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) @(negedge clk);
        chk("post_reset_mode_off", int'(led), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Multi-channel LED driver that generalises the single counter-bit LED toggler.
- Each channel is independently configured to OFF, ON, BLINK or PWM mode.
- A shared prescaler generates a time base for a free-running PWM counter and a blink phase.
- Sits between a simple register-write source (bus bridge or test sequencer) and board LED pins.

Parameters:
CH_NUM, 4, number of LED channels (1..16)
PRESC, 50, clk cycles per time-base tick (>=1); 50 gives 1 us at 50 MHz
PWM_W, 8, PWM counter and duty width; PWM period = 2^PWM_W ticks
BLINK_TICKS, 250000, ticks per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe, sampled on rising clk
cfg_ch  input  max(1,$clog2(CH_NUM))  target channel index
cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
cfg_duty  input  PWM_W  PWM duty; high ticks per period
led  output  CH_NUM  LED drive, registered, active-high
period_start  output  1  one-cycle pulse when the PWM counter wraps to 0

Behaviour:
- Reset, asynchronous on rst_n low, needs no clock edge:
  - All internal state and outputs clear: prescaler, pwm_cnt, blink_cnt, blink_ph, per-channel mode, duty_shadow and duty_act all 0; all modes OFF.
  - led=0, period_start=0.
  - Reset asserted mid-operation forces led=0 immediately.
- Prescaler:
  - pre_cnt counts 0..PRESC-1 and wraps.
  - tick=1 for exactly the one cycle where pre_cnt==PRESC-1.
  - PRESC=1 gives tick every cycle.
- PWM counter:
  - On tick, pwm_cnt increments modulo 2^PWM_W.
  - wrap = tick && pwm_cnt==2^PWM_W-1.
  - period_start is registered: it is 1 in the cycle after the wrap edge, i.e. the same cycle pwm_cnt reads 0.
- Blink:
  - On tick, blink_cnt counts 0..BLINK_TICKS-1.
  - On tick with blink_cnt==BLINK_TICKS-1: blink_cnt goes to 0 and blink_ph toggles.
- Config write (cfg_we high at edge k):
  - mode[cfg_ch] and duty_shadow[cfg_ch] load at edge k.
  - cfg_ch>=CH_NUM: the write is ignored; no state changes.
  - Mode takes effect immediately; led reflects it at edge k+1.
- Duty shadowing:
  - duty_act[i] <= duty_shadow[i] only on the wrap edge.
  - A duty change never truncates or stretches the current period (glitch-free).
  - A write coinciding with the wrap edge: the old shadow is transferred; the new value applies from the following period.
- Output, registered, one cycle after its inputs:
  - OFF: led[i]=0.
  - ON: led[i]=1.
  - BLINK: led[i]=blink_ph; all blinking channels are in phase.
  - PWM: led[i]=(pwm_cnt < duty_act[i]).
    - duty 0 gives a constant 0.
    - duty 2^PWM_W-1 gives high for all but one tick per period.
    - 100% is achieved with ON mode.
- Counters are free-running regardless of channel modes.
- No arithmetic overflow beyond the stated modulo wraps.

Decomposition:
- Shared package led_pkg:
  - Mode localparams MODE_OFF/MODE_ON/MODE_BLINK/MODE_PWM.
  - Mode width constant (2).
- Sub-module led_tick_gen (params PRESC; ports clk, rst_n, tick):
  - Holds the prescaler.
  - Reused by other timing blocks.
- Per-channel logic is a generate loop in the top; no further sub-modules.

Test Plan:
Bench parameters: CH_NUM=3, PRESC=2, PWM_W=4, BLINK_TICKS=3; clk period 20 ns.
1. Reset pulse 8 ns low mid-cycle, then run 200 cycles with no writes -> led==3'b000 throughout. Also pulse rst_n while led[1] is ON -> led drops to 0 within the reset pulse, before any clk edge.
2. Write ch1 mode=ON at edge k -> led[1]=1 from edge k+1, led[0]=led[2]=0. Write ch1 OFF -> led[1]=0 one edge after.
3. ch0 PWM duty=4 -> period_start every 32 clk; led[0] high exactly 8 clk per period, rising one cycle after period_start. duty=0 -> never high.
4. ch2 BLINK -> led[2] toggles every 6 clk (BLINK_TICKS*PRESC); 50% duty cycle.
5. ch0 at duty=4, write duty=12 mid-period -> current period still 8 clk high; next period 24 clk high. A write coincident with wrap applies one period later.
6. Write with cfg_ch=3 (out of range), mode=ON -> no led change, no channel state modified.
